// File: rtl/regfile_write_sched.sv
// Write-port scheduler and long-latency hazard scoreboard for the 32x32 register file.
// Optional `REGSCHED_BYPASS_EN: stall ignores registers being cleared by this cycle's grant.
module regfile_write_sched #(
  parameter int LONG_WAIT_MAX = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_dst,
  input  logic [4:0]  issue_src1,
  input  logic [4:0]  issue_src2,
  output logic        stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_dst,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_dst,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        reg_write,
  output logic [4:0]  use_reg,
  output logic [31:0] data_in,
  output logic [31:0] busy,
  output logic [2:0]  ld_wait,
  output logic [2:0]  md_wait
);

  localparam logic [2:0] WAIT_MAX = 3'(LONG_WAIT_MAX);

  // last = 1 means load won the most recent shared grant, so MDU is preferred next
  logic        last;
  logic        ld_gnt;
  logic        md_gnt;
  logic [31:0] clr_now;
  logic [31:0] set_now;
  logic [31:0] busy_eff;

  always_comb begin
    ld_gnt = ld_valid && !alu_valid && (!md_valid || !last);
    md_gnt = md_valid && !alu_valid && (!ld_valid || last);
  end

  assign ld_ready = ld_gnt;
  assign md_ready = md_gnt;

  always_comb begin
    clr_now = '0;
    if (ld_gnt)
      clr_now[ld_dst] = 1'b1;
    else if (md_gnt)
      clr_now[md_dst] = 1'b1;
  end

`ifdef REGSCHED_BYPASS_EN
  assign busy_eff = busy & ~clr_now;
`else
  assign busy_eff = busy;
`endif

  always_comb begin
    stall = issue_valid &&
            (busy_eff[issue_src1] || busy_eff[issue_src2] ||
             (issue_long && busy_eff[issue_dst]));
  end

  always_comb begin
    set_now = '0;
    if (issue_valid && issue_long && !stall && (issue_dst != 5'd0))
      set_now[issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      last <= 1'b0;
    end else begin
      busy <= ((busy & ~clr_now) | set_now) & 32'hFFFF_FFFE;
      if (ld_gnt)
        last <= 1'b1;
      else if (md_gnt)
        last <= 1'b0;
    end
  end

  // a dst-0 grant is consumed but never raises the write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      use_reg   <= '0;
      data_in   <= '0;
    end else if (alu_valid) begin
      reg_write <= (alu_dst != 5'd0);
      use_reg   <= alu_dst;
      data_in   <= alu_data;
    end else if (ld_gnt) begin
      reg_write <= (ld_dst != 5'd0);
      use_reg   <= ld_dst;
      data_in   <= ld_data;
    end else if (md_gnt) begin
      reg_write <= (md_dst != 5'd0);
      use_reg   <= md_dst;
      data_in   <= md_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_wait <= '0;
      md_wait <= '0;
    end else begin
      if (!ld_valid || ld_gnt)
        ld_wait <= '0;
      else if (ld_wait != WAIT_MAX)
        ld_wait <= ld_wait + 3'd1;

      if (!md_valid || md_gnt)
        md_wait <= '0;
      else if (md_wait != WAIT_MAX)
        md_wait <= md_wait + 3'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench for regfile_write_sched: stimulus pushes expected writes, a monitor pops them.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 0, issue_long = 0;
  logic [4:0]  issue_dst = 0, issue_src1 = 0, issue_src2 = 0;
  logic        stall;
  logic        alu_valid = 0;
  logic [4:0]  alu_dst = 0;
  logic [31:0] alu_data = 0;
  logic        ld_valid = 0;
  logic [4:0]  ld_dst = 0;
  logic [31:0] ld_data = 0;
  logic        ld_ready;
  logic        md_valid = 0;
  logic [4:0]  md_dst = 0;
  logic [31:0] md_data = 0;
  logic        md_ready;
  logic        reg_write;
  logic [4:0]  use_reg;
  logic [31:0] data_in;
  logic [31:0] busy;
  logic [2:0]  ld_wait, md_wait;

  regfile_write_sched #(.LONG_WAIT_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_dst(issue_dst),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .stall(stall),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_dst(md_dst), .md_data(md_data), .md_ready(md_ready),
    .reg_write(reg_write), .use_reg(use_reg), .data_in(data_in), .busy(busy),
    .ld_wait(ld_wait), .md_wait(md_wait)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];
  logic m_last = 1'b0;
  logic dut_ld, dut_md;

`ifdef REGSCHED_BYPASS_EN
  localparam logic STALL_IN_GRANT = 1'b0;
`else
  localparam logic STALL_IN_GRANT = 1'b1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // samples grants mid-cycle against the arbitration model, then advances one clock
  task automatic tick();
    logic el, em;
    @(negedge clk);
    el = ld_valid && !alu_valid && (!md_valid || !m_last);
    em = md_valid && !alu_valid && (!ld_valid || m_last);
    dut_ld = ld_ready;
    dut_md = md_ready;
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, el});
    chk("md_ready", {31'd0, md_ready}, {31'd0, em});
    if (alu_valid) begin
      if (alu_dst != 0) exp_q.push_back({alu_dst, alu_data});
    end else if (el) begin
      if (ld_dst != 0) exp_q.push_back({ld_dst, ld_data});
      m_last = 1'b1;
    end else if (em) begin
      if (md_dst != 0) exp_q.push_back({md_dst, md_data});
      m_last = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", use_reg, data_in);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, use_reg}, {27'd0, e[36:32]});
        chk("wr_data", data_in, e[31:0]);
      end
    end
  end

  initial begin
    int li, mi, g;
    logic [3:0] rr_seen;
    logic [4:0] ld_tbl[2];
    logic [4:0] md_tbl[2];
    ld_tbl[0] = 5'd10; ld_tbl[1] = 5'd11;
    md_tbl[0] = 5'd20; md_tbl[1] = 5'd21;

    #12 rst = 1'b0;
    #1;
    chk("rst_reg_write", {31'd0, reg_write}, 0);
    chk("rst_use_reg", {27'd0, use_reg}, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_waits", {26'd0, ld_wait, md_wait}, 0);
    @(posedge clk); #1;

    // round-robin between load and MDU
    li = 0; mi = 0; g = 0; rr_seen = '0;
    for (int c = 0; c < 8 && g < 4; c++) begin
      ld_valid = (li < 2);
      ld_dst   = ld_tbl[(li < 2) ? li : 0];
      ld_data  = 32'h1000_0000 + 32'(ld_dst);
      md_valid = (mi < 2);
      md_dst   = md_tbl[(mi < 2) ? mi : 0];
      md_data  = 32'h2000_0000 + 32'(md_dst);
      tick();
      if (dut_ld) begin rr_seen[g] = 1'b0; g++; li++; end
      else if (dut_md) begin rr_seen[g] = 1'b1; g++; mi++; end
      chk("rr_ld_wait_le1", {31'd0, ld_wait <= 3'd1}, 1);
      chk("rr_md_wait_le1", {31'd0, md_wait <= 3'd1}, 1);
    end
    ld_valid = 0; md_valid = 0;
    chk("rr_grants", g, 4);
    chk("rr_order", {28'd0, rr_seen}, 32'b1010);

    // ALU beats load, load follows next cycle
    alu_valid = 1; alu_dst = 8; alu_data = 32'hA1A1_0008;
    ld_valid = 1; ld_dst = 9; ld_data = 32'hB2B2_0009;
    tick();
    chk("cont_ld_ready", {31'd0, dut_ld}, 0);
    chk("cont_ld_wait", {29'd0, ld_wait}, 1);
    chk("cont_reg_write", {31'd0, reg_write}, 1);
    alu_valid = 0;
    tick();
    chk("cont_ld_gnt", {31'd0, dut_ld}, 1);
    chk("cont_ld_wait_clr", {29'd0, ld_wait}, 0);
    ld_valid = 0;

    // RAW hazard on r4 cleared by an MDU return
    issue_valid = 1; issue_long = 1; issue_dst = 4; issue_src1 = 1; issue_src2 = 2;
    #1 chk("raw_prod_stall", {31'd0, stall}, 0);
    tick();
    chk("raw_busy_set", busy, 32'h10);
    issue_long = 0; issue_dst = 7; issue_src1 = 4;
    #1 chk("raw_stall_a", {31'd0, stall}, 1);
    tick();
    chk("raw_stall_b", {31'd0, stall}, 1);
    md_valid = 1; md_dst = 4; md_data = 32'h0000_4444;
    #1 chk("raw_stall_grant", {31'd0, stall}, {31'd0, STALL_IN_GRANT});
    tick();
    chk("raw_md_gnt", {31'd0, dut_md}, 1);
    md_valid = 0;
    chk("raw_busy_clr", busy, 0);
    chk("raw_stall_after", {31'd0, stall}, 0);
    tick();
    issue_valid = 0;

    // register 0 load is consumed without a write
    ld_valid = 1; ld_dst = 0; ld_data = 32'hDEAD_BEEF;
    tick();
    chk("r0_ld_ready", {31'd0, dut_ld}, 1);
    chk("r0_reg_write", {31'd0, reg_write}, 0);
    chk("r0_busy", busy, 0);
    ld_valid = 0;

    // asynchronous reset mid-operation
    issue_valid = 1; issue_long = 1; issue_dst = 4; issue_src1 = 0; issue_src2 = 0;
    tick();
    issue_dst = 5;
    tick();
    issue_valid = 0;
    chk("mid_busy", busy, 32'h30);
    alu_valid = 1; alu_dst = 0; alu_data = 32'h1;
    ld_valid = 1; ld_dst = 12; ld_data = 32'hC;
    tick();
    tick();
    chk("mid_ld_wait", {29'd0, ld_wait}, 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_reg_write", {31'd0, reg_write}, 0);
    chk("arst_ld_wait", {29'd0, ld_wait}, 0);
    alu_valid = 0; ld_valid = 0; issue_long = 0;
    m_last = 1'b0;
    exp_q.delete();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    ld_valid = 1; ld_dst = 13; ld_data = 32'h0000_0D0D;
    md_valid = 1; md_dst = 14; md_data = 32'h0000_0E0E;
    tick();
    chk("arst_tie_ld", {31'd0, dut_ld}, 1);
    ld_valid = 0;
    tick();
    chk("arst_md_next", {31'd0, dut_md}, 1);
    md_valid = 0;

    // starvation: ALU hogs the port for 10 cycles
    ld_valid = 1; ld_dst = 15; ld_data = 32'hF00D_000F;
    for (int k = 1; k <= 10; k++) begin
      alu_valid = 1; alu_dst = 5'(16 + k); alu_data = 32'(k);
      tick();
      chk("starve_ld_wait", {29'd0, ld_wait}, (k < 7) ? k : 7);
    end
    alu_valid = 0;
    tick();
    chk("starve_ld_gnt", {31'd0, dut_ld}, 1);
    chk("starve_wait_clr", {29'd0, ld_wait}, 0);
    ld_valid = 0;

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
